// File: rtl/mem_reinit_ctrl_if.sv
// Host access bus for mem_reinit_ctrl: request/grant handshake plus read return.
interface mem_reinit_ctrl_if #(
    parameter int WID_MEM = 128
);
    logic               host_req;
    logic               host_we;
    logic [31:0]        host_addr;
    logic [WID_MEM-1:0] host_wdata;
    logic               host_gnt;
    logic               host_rvalid;
    logic [WID_MEM-1:0] host_rdata;

    // Host side drives requests and receives grant/read data.
    modport master (
        output host_req, host_we, host_addr, host_wdata,
        input  host_gnt, host_rvalid, host_rdata
    );

    // Controller side accepts requests and returns grant/read data.
    modport slave (
        input  host_req, host_we, host_addr, host_wdata,
        output host_gnt, host_rvalid, host_rdata
    );
endinterface

// File: rtl/mem_reinit_ctrl.sv
// Fill/verify sequencer and host arbiter in front of one simple-dual-port RAM.
// A sweep writes the latched pattern to every word, reads every word back,
// and records the first mismatching address. Outside a sweep the host owns the RAM.
module mem_reinit_ctrl #(
    parameter int WID_MEM   = 128,
    parameter int DEPTH_MEM = 128
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start_reinit,
    input  logic [WID_MEM-1:0] fill_pattern,
    mem_reinit_ctrl_if.slave   host,
    output logic [31:0]        mem_raddr,
    output logic [31:0]        mem_waddr,
    output logic [WID_MEM-1:0] mem_din,
    output logic               mem_we,
    input  logic [WID_MEM-1:0] mem_dout,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [31:0]        err_addr
);
    localparam int AW = (DEPTH_MEM > 1) ? $clog2(DEPTH_MEM) : 1;
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH_MEM - 1);

    typedef enum logic [1:0] {IDLE, FILL, VERIFY, CHECK} state_t;

    state_t             state;
    logic [AW-1:0]      addr;
    logic [WID_MEM-1:0] pattern;
    logic               cmp_valid;
    logic [AW-1:0]      cmp_addr;
    logic               rvalid;
    logic               rd_oor;

    logic               host_in_range;
    logic               grant;

    assign host_in_range = (host.host_addr < 32'(DEPTH_MEM));
    // Start wins over a simultaneous host request; nothing is granted in reset.
    assign grant = reset_n && (state == IDLE) && !start_reinit && host.host_req;

    assign host.host_gnt    = grant;
    assign host.host_rvalid = rvalid;
    // Out-of-range reads return zero instead of whatever the RAM wrapper produced.
    assign host.host_rdata  = rd_oor ? '0 : mem_dout;
    assign busy             = (state != IDLE);

    // RAM port steering: host in IDLE, counter-driven during the sweep.
    always_comb begin
        mem_raddr = '0;
        mem_waddr = '0;
        mem_din   = '0;
        mem_we    = 1'b0;
        case (state)
            IDLE: begin
                if (grant) begin
                    mem_raddr = host.host_addr;
                    mem_waddr = host.host_addr;
                    mem_din   = host.host_wdata;
                    mem_we    = host.host_we && host_in_range;
                end
            end
            FILL: begin
                mem_waddr = 32'(addr);
                mem_din   = pattern;
                mem_we    = 1'b1;
            end
            VERIFY: begin
                mem_raddr = 32'(addr);
            end
            default: begin
            end
        endcase
    end

    // Sweep FSM, compare pipeline and registered status/host read outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            addr      <= '0;
            pattern   <= '0;
            cmp_valid <= 1'b0;
            cmp_addr  <= '0;
            rvalid    <= 1'b0;
            rd_oor    <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            err_addr  <= '0;
        end else begin
            done      <= 1'b0;
            rvalid    <= 1'b0;
            cmp_valid <= 1'b0;

            // Data for the address pushed last cycle is on mem_dout now.
            if (cmp_valid && (mem_dout != pattern) && !err) begin
                err      <= 1'b1;
                err_addr <= 32'(cmp_addr);
            end

            case (state)
                IDLE: begin
                    if (start_reinit) begin
                        pattern  <= fill_pattern;
                        addr     <= '0;
                        err      <= 1'b0;
                        err_addr <= '0;
                        state    <= FILL;
                    end else if (grant && !host.host_we) begin
                        rvalid <= 1'b1;
                        rd_oor <= !host_in_range;
                    end
                end
                FILL: begin
                    if (addr == LAST_ADDR) begin
                        addr  <= '0;
                        state <= VERIFY;
                    end else begin
                        addr <= addr + AW'(1);
                    end
                end
                VERIFY: begin
                    cmp_valid <= 1'b1;
                    cmp_addr  <= addr;
                    if (addr == LAST_ADDR) begin
                        addr  <= '0;
                        state <= CHECK;
                    end else begin
                        addr <= addr + AW'(1);
                    end
                end
                CHECK: begin
                    state <= IDLE;
                    done  <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_reinit_ctrl.sv
// Scoreboard bench for mem_reinit_ctrl with a behavioural registered-read RAM.
module tb_mem_reinit_ctrl;
    localparam int W = 128;
    localparam int D = 128;
    localparam int SWEEP_LAT = 2 * D + 1;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start_reinit = 1'b0;
    logic [W-1:0]  fill_pattern = '0;
    logic [31:0]   mem_raddr, mem_waddr;
    logic [W-1:0]  mem_din;
    logic          mem_we;
    logic [W-1:0]  mem_dout = '0;
    logic          busy, done, err;
    logic [31:0]   err_addr;
    logic          corrupt_en = 1'b0;

    int cyc = 0;
    int errors = 0;
    int checks = 0;

    mem_reinit_ctrl_if #(.WID_MEM(W)) hif ();

    mem_reinit_ctrl #(.WID_MEM(W), .DEPTH_MEM(D)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start_reinit (start_reinit),
        .fill_pattern (fill_pattern),
        .host         (hif),
        .mem_raddr    (mem_raddr),
        .mem_waddr    (mem_waddr),
        .mem_din      (mem_din),
        .mem_we       (mem_we),
        .mem_dout     (mem_dout),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .err_addr     (err_addr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural RAM: registered read, out-of-range reads return all ones.
    logic [W-1:0] ram [0:D-1];
    initial for (int i = 0; i < D; i++) ram[i] = '0;
    always @(posedge clk) begin
        if (mem_we && mem_waddr < D) ram[mem_waddr[6:0]] <= mem_din;
        if (mem_raddr < D)
            mem_dout <= ram[mem_raddr[6:0]] ^
                        ((corrupt_en && (mem_raddr == 17 || mem_raddr == 40)) ? W'(1) : W'(0));
        else
            mem_dout <= '1;
    end

    typedef struct { logic [W-1:0] data; int cyc; } rd_exp_t;
    typedef struct { logic e; logic [31:0] a; int cyc; } done_exp_t;
    rd_exp_t   rd_q[$];
    done_exp_t done_q[$];

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: pops an expectation whenever the DUT presents read data or done.
    always @(negedge clk) begin
        if (reset_n) begin
            if (hif.host_rvalid) begin
                if (rd_q.size() == 0) begin
                    chk("unexpected_rvalid", 1, 0);
                end else begin
                    rd_exp_t r;
                    r = rd_q.pop_front();
                    chk("rdata", hif.host_rdata, r.data);
                    chk("rvalid_cycle", W'(cyc), W'(r.cyc));
                    $display("host read: rdata=%h cyc=%0d", hif.host_rdata, cyc);
                end
            end
            if (done) begin
                if (done_q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    done_exp_t d;
                    d = done_q.pop_front();
                    chk("done_err", W'(err), W'(d.e));
                    chk("done_err_addr", W'(err_addr), W'(d.a));
                    chk("done_cycle", W'(cyc), W'(d.cyc));
                    $display("sweep done: err=%0b err_addr=%0d cyc=%0d", err, err_addr, cyc);
                end
            end
        end
    end

    task automatic wait_drain();
        int n = 0;
        while ((rd_q.size() != 0 || done_q.size() != 0) && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (rd_q.size() != 0 || done_q.size() != 0) begin
            chk("drain_timeout", 1, 0);
            rd_q.delete();
            done_q.delete();
        end
        @(negedge clk);
    endtask

    task automatic host_access(input logic we, input logic [31:0] a, input logic [W-1:0] wd,
                               input logic [W-1:0] exp, input logic exp_we);
        int n = 0;
        @(negedge clk);
        hif.host_req = 1'b1; hif.host_we = we; hif.host_addr = a; hif.host_wdata = wd;
        #1;
        while (!hif.host_gnt && n < 400) begin
            @(negedge clk); #1;
            n++;
        end
        if (!hif.host_gnt) begin
            chk("gnt_timeout", 1, 0);
        end else if (we) begin
            chk("host_mem_we", W'(mem_we), W'(exp_we));
            $display("host write: addr=%0d data=%h mem_we=%0b", a, wd, mem_we);
        end else begin
            rd_q.push_back('{exp, cyc + 1});
        end
        @(posedge clk); #1;
        hif.host_req = 1'b0; hif.host_we = 1'b0;
        wait_drain();
    endtask

    // Starts a sweep; scrambles fill_pattern after acceptance to prove it is latched.
    task automatic start_sweep(input logic [W-1:0] pat, input logic exp_err, input logic [31:0] exp_addr,
                               input logic queue_done);
        @(negedge clk);
        fill_pattern = pat;
        start_reinit = 1'b1;
        @(posedge clk); #1;
        start_reinit = 1'b0;
        fill_pattern = ~pat;
        if (queue_done) done_q.push_back('{exp_err, exp_addr, cyc + SWEEP_LAT});
        chk("busy_after_accept", W'(busy), 1);
        chk("err_cleared_on_accept", W'(err), 0);
    endtask

    initial begin
        logic [W-1:0] pa5, p3c, p0f, p12;
        int bad;
        pa5 = {16{8'hA5}};
        p3c = {16{8'h3C}};
        p0f = {16{8'h0F}};
        p12 = {4{32'h1234_5678}};
        hif.host_req = 1'b1; hif.host_we = 1'b1; hif.host_addr = 32'd1; hif.host_wdata = '1;

        // Reset state with a pending host write request.
        repeat (2) @(negedge clk);
        chk("rst_gnt", W'(hif.host_gnt), 0);
        chk("rst_mem_we", W'(mem_we), 0);
        chk("rst_busy", W'(busy), 0);
        chk("rst_done", W'(done), 0);
        chk("rst_err", W'(err), 0);
        chk("rst_err_addr", W'(err_addr), 0);
        chk("rst_rvalid", W'(hif.host_rvalid), 0);
        hif.host_req = 1'b0; hif.host_we = 1'b0;
        reset_n = 1'b1;

        // Host write/read round trip.
        host_access(1'b1, 32'd5, W'(32'hDEAD), '0, 1'b1);
        host_access(1'b0, 32'd5, '0, W'(32'hDEAD), 1'b0);

        // Out-of-range write is dropped, read returns zero.
        host_access(1'b1, 32'd200, W'(32'hBEEF), '0, 1'b0);
        host_access(1'b0, 32'd200, '0, '0, 1'b0);

        // Clean sweep.
        start_sweep(pa5, 1'b0, 32'd0, 1'b1);
        wait_drain();
        bad = 0;
        for (int i = 0; i < D; i++) if (ram[i] !== pa5) bad++;
        chk("ram_all_a5", W'(bad), 0);

        // Corrupted reads at 17 and 40: first failing address is kept.
        corrupt_en = 1'b1;
        start_sweep(p3c, 1'b1, 32'd17, 1'b1);
        wait_drain();
        corrupt_en = 1'b0;
        chk("err_sticky", W'(err), 1);
        chk("err_addr_sticky", W'(err_addr), 17);

        // Simultaneous start and host read: start wins, host served in first IDLE cycle.
        begin
            int n = 0;
            @(negedge clk);
            fill_pattern = p0f; start_reinit = 1'b1;
            hif.host_req = 1'b1; hif.host_we = 1'b0; hif.host_addr = 32'd7;
            #1;
            chk("start_prio_gnt", W'(hif.host_gnt), 0);
            @(posedge clk); #1;
            start_reinit = 1'b0; fill_pattern = '0;
            done_q.push_back('{1'b0, 32'd0, cyc + SWEEP_LAT});
            repeat (50) @(negedge clk);
            #1;
            chk("gnt_during_sweep", W'(hif.host_gnt), 0);
            chk("busy_during_sweep", W'(busy), 1);
            while (!hif.host_gnt && n < 400) begin
                @(negedge clk); #1;
                n++;
            end
            if (!hif.host_gnt) begin
                chk("post_sweep_gnt_timeout", 1, 0);
            end else begin
                chk("gnt_in_done_cycle", W'(done), 1);
                rd_q.push_back('{p0f, cyc + 1});
            end
            @(posedge clk); #1;
            hif.host_req = 1'b0;
            wait_drain();
        end

        // Reset in the middle of FILL: sweep abandoned, no done, RAM partly rewritten.
        start_sweep(p12, 1'b0, 32'd0, 1'b0);
        repeat (20) @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        chk("midrst_busy", W'(busy), 0);
        chk("midrst_mem_we", W'(mem_we), 0);
        chk("midrst_done", W'(done), 0);
        chk("midrst_err", W'(err), 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (300) @(negedge clk);
        host_access(1'b0, 32'd3, '0, p12, 1'b0);
        host_access(1'b0, 32'd50, '0, p0f, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end
endmodule
